acc_seq: RTL

Accumulator read-modify-write sequencer that sits directly upstream of the accumulator register bit slices. It samples the slice outputs (`aout`) and a memory operand, computes the next accumulator value, presents it on `ain`, and generates the `wra` write strobe. For stores it also generates the `rda` read strobe that lets the slices drive the open-drain data bus. It owns the link bit and a zero flag, and runs one operation at a time under a start/busy/done handshake.

---
 rtl/acc_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/acc_seq.sv
// acc_seq: accumulator read-modify-write sequencer.
// Latches op/operand/aout on start, computes the next accumulator value,
// presents it on ain and strobes wra (and rda first, for a store).
// Optional feature macro: ACC_SEQ_ROTATE_EN enables RAL/RAR; when undefined
// opcodes 110/111 complete as NOP and the rotate logic is not built.
module acc_seq #(
  parameter int WIDTH     = 12,
  parameter int WRA_PULSE = 1,
  parameter int RDA_PULSE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] aout,
  output logic [WIDTH-1:0] ain,
  output logic             wra,
  output logic             rda,
  output logic             link,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_CLA = 3'b001;
  localparam logic [2:0] OP_TAD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_DCA = 3'b100;
  localparam logic [2:0] OP_CMA = 3'b101;
`ifdef ACC_SEQ_ROTATE_EN
  localparam logic [2:0] OP_RAL = 3'b110;
  localparam logic [2:0] OP_RAR = 3'b111;
`endif

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opd_q, acc_q;
  logic [WIDTH-1:0] res;
  logic             res_link;
  logic [WIDTH:0]   sum;
  logic             op_is_nop;
  logic             wra_nxt, rda_nxt, busy_nxt, done_nxt;

  // Opcodes that complete without any write
`ifdef ACC_SEQ_ROTATE_EN
  assign op_is_nop = (op == OP_NOP);
`else
  assign op_is_nop = (op == OP_NOP) || (op[2:1] == 2'b11);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; pulse lengths are counted by cnt within a state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) begin
                 if (op == OP_DCA)  state_nxt = S_READ;
                 else if (op_is_nop) state_nxt = S_DONE;
                 else                state_nxt = S_CALC;
               end
      S_READ:  if (cnt == 2'(RDA_PULSE - 1)) state_nxt = S_CALC;
      S_CALC:  state_nxt = S_WRITE;
      S_WRITE: if (cnt == 2'(WRA_PULSE - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes are looked-ahead from state_nxt so they come from flops
  always_comb begin
    wra_nxt  = (state_nxt == S_WRITE);
    rda_nxt  = (state_nxt == S_READ);
    done_nxt = (state_nxt == S_DONE);
    busy_nxt = (state_nxt != S_IDLE);
  end

  // Strobe/status flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wra  <= 1'b0;
      rda  <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      wra  <= wra_nxt;
      rda  <= rda_nxt;
      done <= done_nxt;
      busy <= busy_nxt;
    end
  end

  // Pulse counter restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else                         cnt <= cnt + 2'd1;
  end

  // Capture the request; start is ignored outside IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_NOP;
      opd_q <= '0;
      acc_q <= '0;
    end else if (state == S_IDLE && start) begin
      op_q  <= op;
      opd_q <= operand;
      acc_q <= aout;
    end
  end

  assign sum = {1'b0, acc_q} + {1'b0, opd_q};

  // Result datapath; link holds unless TAD/RAL/RAR change it
  always_comb begin
    res      = acc_q;
    res_link = link;
    unique case (op_q)
      OP_CLA: res = '0;
      OP_TAD: begin
        res      = sum[WIDTH-1:0];
        res_link = link ^ sum[WIDTH];
      end
      OP_AND: res = acc_q & opd_q;
      OP_DCA: res = '0;
      OP_CMA: res = ~acc_q;
`ifdef ACC_SEQ_ROTATE_EN
      OP_RAL: begin
        res      = {acc_q[WIDTH-2:0], link};
        res_link = acc_q[WIDTH-1];
      end
      OP_RAR: begin
        res      = {link, acc_q[WIDTH-1:1]};
        res_link = acc_q[0];
      end
`endif
      default: begin
        res      = acc_q;
        res_link = link;
      end
    endcase
  end

  // Architectural result registers, updated only at the CALC exit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ain  <= '0;
      link <= 1'b0;
      zero <= 1'b1;
    end else if (state == S_CALC) begin
      ain  <= res;
      link <= res_link;
      zero <= (res == '0);
    end
  end

endmodule
